// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serialises packed config words MSB-first onto ccff_head,
// gates the fabric chain clock via ccff_shift_en, and streams back the displaced tail bits.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 8,
    parameter int WORD_W    = 4
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              rb_bit,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);

    localparam int BLW    = $clog2(CHAIN_LEN + 1);
    localparam int CW     = $clog2(WORD_W + 1);
    localparam int MW     = (BLW > CW) ? BLW : CW;
    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int WLW    = $clog2(NWORDS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [WORD_W-1:0] sr_reg;
    logic [CW-1:0]     sr_cnt_reg;
    logic [BLW-1:0]    bits_left_reg;
    logic [WLW-1:0]    words_left_reg;
    logic              rb_bit_reg;
    logic              rb_valid_reg;

    logic              shift;
    logic              accept;
    logic [BLW-1:0]    bits_after;
    logic [CW-1:0]     load_cnt;

    assign shift         = (state_reg == LOAD) && (sr_cnt_reg != '0);
    assign ccff_shift_en = shift;
    assign ccff_head     = sr_reg[WORD_W-1];
    assign busy          = (state_reg == LOAD);
    assign done          = (state_reg == DONE);
    assign rb_bit        = rb_bit_reg;
    assign rb_valid      = rb_valid_reg;

    // A new word may land on the same edge that shifts out the last buffered bit,
    // which keeps the chain clock running without a bubble.
    assign in_ready = (state_reg == LOAD) && (words_left_reg != '0) &&
                      ((sr_cnt_reg == '0) || ((sr_cnt_reg == CW'(1)) && shift));
    assign accept   = in_valid && in_ready;

    // Final word is trimmed to the bits the chain still needs; its spare LSBs never shift.
    always_comb begin
        bits_after = shift ? (bits_left_reg - BLW'(1)) : bits_left_reg;
        load_cnt   = CW'(WORD_W);
        if (MW'(bits_after) < MW'(WORD_W)) begin
            load_cnt = CW'(bits_after);
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_reg      <= IDLE;
            sr_reg         <= '0;
            sr_cnt_reg     <= '0;
            bits_left_reg  <= '0;
            words_left_reg <= '0;
            rb_bit_reg     <= 1'b0;
            rb_valid_reg   <= 1'b0;
        end else begin
            rb_valid_reg <= shift;
            if (shift) begin
                rb_bit_reg <= ccff_tail;
            end

            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg      <= LOAD;
                        bits_left_reg  <= BLW'(CHAIN_LEN);
                        sr_cnt_reg     <= '0;
                        words_left_reg <= WLW'(NWORDS);
                    end
                end
                LOAD: begin
                    if (shift) begin
                        sr_reg        <= sr_reg << 1;
                        sr_cnt_reg    <= sr_cnt_reg - CW'(1);
                        bits_left_reg <= bits_after;
                        if (bits_left_reg == BLW'(1)) begin
                            state_reg <= DONE;
                        end
                    end
                    if (accept) begin
                        sr_reg         <= in_data;
                        sr_cnt_reg     <= load_cnt;
                        words_left_reg <= words_left_reg - WLW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: an 8-bit chain instance with a shift-register
// chain model on its tail, plus a 10-bit chain instance for the partial-final-word case.
module tb_ccff_chain_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [3:0] in_data;
    logic       sel;

    logic start8, iv8, rdy8, head8, se8, tail8, rbb8, rbv8, busy8, done8;
    logic start10, iv10, rdy10, head10, se10, rbb10, rbv10, busy10, done10;
    logic obs_ready, obs_head, obs_shift, obs_rb, obs_rbv, obs_busy, obs_done;

    assign start8   = start & ~sel;
    assign iv8      = in_valid & ~sel;
    assign start10  = start & sel;
    assign iv10     = in_valid & sel;

    assign obs_ready = sel ? rdy10  : rdy8;
    assign obs_head  = sel ? head10 : head8;
    assign obs_shift = sel ? se10   : se8;
    assign obs_rb    = sel ? rbb10  : rbb8;
    assign obs_rbv   = sel ? rbv10  : rbv8;
    assign obs_busy  = sel ? busy10 : busy8;
    assign obs_done  = sel ? done10 : done8;

    ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(4)) dut (
        .prog_clk      (clk),
        .prog_reset_n  (rst_n),
        .start         (start8),
        .in_data       (in_data),
        .in_valid      (iv8),
        .in_ready      (rdy8),
        .ccff_head     (head8),
        .ccff_shift_en (se8),
        .ccff_tail     (tail8),
        .rb_bit        (rbb8),
        .rb_valid      (rbv8),
        .busy          (busy8),
        .done          (done8)
    );

    ccff_chain_loader #(.CHAIN_LEN(10), .WORD_W(4)) dut10 (
        .prog_clk      (clk),
        .prog_reset_n  (rst_n),
        .start         (start10),
        .in_data       (in_data),
        .in_valid      (iv10),
        .in_ready      (rdy10),
        .ccff_head     (head10),
        .ccff_shift_en (se10),
        .ccff_tail     (1'b0),
        .rb_bit        (rbb10),
        .rb_valid      (rbv10),
        .busy          (busy10),
        .done          (done10)
    );

    // Downstream chain model: head enters bit 0, tail is bit 7.
    logic [7:0] chain;
    logic [7:0] pre_val;
    logic       pre_req;
    assign tail8 = chain[7];
    always @(posedge clk) begin
        if (pre_req)  chain <= pre_val;
        else if (se8) chain <= {chain[6:0], head8};
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [3:0]  w [4];
    logic [15:0] head_seq, rb_seq;
    int          n_shift, n_rb, gap, n_rdy, rdy_first, rdy_second, n_acc;
    logic        got_done;

    task automatic preload(input logic [7:0] v);
        pre_val = v;
        pre_req = 1'b1;
        @(negedge clk);
        pre_req = 1'b0;
    endtask

    // Runs one load: nw words from w[], second word withheld for `stall` ready cycles,
    // optional extra start pulse in cycle xstart. Samples everything on the falling edge.
    task automatic run_load(input string name, input int nw, input int stall, input int xstart);
        int   widx, stall_cnt;
        logic seen, withhold;
        head_seq = '0; rb_seq = '0; n_shift = 0; n_rb = 0; gap = 0; n_rdy = 0;
        rdy_first = 0; rdy_second = 0; n_acc = 0; got_done = 1'b0;
        seen = 1'b0; widx = 0; stall_cnt = 0;
        start = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (obs_shift) begin
                head_seq = {head_seq[14:0], obs_head};
                n_shift++;
                seen = 1'b1;
            end else if (obs_busy && seen) begin
                gap++;
            end
            if (obs_rbv) begin
                rb_seq = {rb_seq[14:0], obs_rb};
                n_rb++;
            end
            if (obs_ready) begin
                n_rdy++;
                if (n_rdy == 1) rdy_first = cyc;
                if (n_rdy == 2) rdy_second = cyc;
            end
            if (obs_done) begin
                got_done = 1'b1;
                break;
            end
            withhold = (widx == 1) && (stall_cnt < stall);
            if (withhold && obs_ready) stall_cnt++;
            in_valid = (widx < nw) && !withhold;
            if (widx < nw) in_data = w[widx];
            if (in_valid && obs_ready) begin
                widx++;
                n_acc++;
            end
            start = (cyc == xstart);
            @(negedge clk);
        end
        in_valid = 1'b0;
        start = 1'b0;
        check({name, "_done"}, got_done, 1'b1);
        $display("load %s: head=%0h shifts=%0d rb=%0h rb_pulses=%0d gap=%0d words=%0d",
                 name, head_seq, n_shift, rb_seq, n_rb, gap, n_acc);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; sel = 1'b0;
        pre_req = 1'b0; pre_val = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_out8",  {rdy8, head8, se8, rbb8, rbv8, busy8, done8}, 7'd0);
        check("reset_out10", {rdy10, head10, se10, rbb10, rbv10, busy10, done10}, 7'd0);
        preload(8'h00);

        // Basic gapless load of A,5
        w[0] = 4'hA; w[1] = 4'h5;
        run_load("basic", 2, 0, 0);
        check("basic_head",   head_seq[7:0], 8'hA5);
        check("basic_shifts", n_shift, 8);
        check("basic_gap",    gap, 0);
        check("basic_nrdy",   n_rdy, 2);
        check("basic_rdy_sp", rdy_second - rdy_first, 4);
        check("basic_busy",   obs_busy, 1'b0);
        check("basic_rb",     rb_seq[7:0], 8'h00);
        check("basic_rbn",    n_rb, 8);

        // Second word withheld for 3 ready cycles
        run_load("stall", 2, 3, 0);
        check("stall_head",   head_seq[7:0], 8'hA5);
        check("stall_shifts", n_shift, 8);
        check("stall_gap",    gap, 3);
        check("stall_rb",     rb_seq[7:0], 8'hA5);

        // start pulse mid-load must be ignored
        w[0] = 4'h3; w[1] = 4'hC;
        run_load("xstart", 2, 0, 3);
        check("xstart_head",   head_seq[7:0], 8'h3C);
        check("xstart_shifts", n_shift, 8);
        check("xstart_rb",     rb_seq[7:0], 8'hA5);

        // in_valid while in DONE is ignored
        bad = 0;
        in_valid = 1'b1; in_data = 4'hF;
        repeat (3) begin
            @(negedge clk);
            if (rdy8 || se8 || !done8) bad++;
        end
        in_valid = 1'b0;
        check("done_ignore", bad, 0);

        // Readback of preloaded chain contents
        preload(8'hC3);
        w[0] = 4'h0; w[1] = 4'h0;
        run_load("rb1", 2, 0, 0);
        check("rb1_bits", rb_seq[7:0], 8'hC3);
        check("rb1_n",    n_rb, 8);
        run_load("rb2", 2, 0, 0);
        check("rb2_bits", rb_seq[7:0], 8'h00);
        check("rb2_n",    n_rb, 8);

        // Asynchronous reset in the middle of a load
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 4'hF;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_shift", {se8, busy8}, 2'b11);
        #2 rst_n = 1'b0;
        #1 check("mid_reset_out", {rdy8, head8, se8, rbb8, rbv8, busy8, done8}, 7'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (se8 || rdy8 || busy8 || done8) bad++;
        end
        in_valid = 1'b0;
        check("post_reset_idle", bad, 0);
        $display("reset mid-load: idle violations=%0d", bad);

        w[0] = 4'hA; w[1] = 4'h5;
        run_load("reload", 2, 0, 0);
        check("reload_head",   head_seq[7:0], 8'hA5);
        check("reload_shifts", n_shift, 8);

        // Partial final word on the 10-bit chain; a 4th word must never be readied
        sel = 1'b1;
        w[0] = 4'hF; w[1] = 4'h0; w[2] = 4'hB; w[3] = 4'h7;
        run_load("part10", 4, 0, 0);
        check("part_head",   head_seq[9:0], 10'h3C2);
        check("part_shifts", n_shift, 10);
        check("part_words",  n_acc, 3);
        check("part_rbn",    n_rb, 10);
        check("part_rdy_done", obs_ready, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
